load_buffer: RTL

Queues load micro-ops whose effective address the address unit has computed, and issues them one at a time, oldest first, to the memory controller. It sign- or zero-extends the returned data and broadcasts the result with its ROB tag on the common data bus. It sits between the address unit (upstream) and the memory controller and CDB (downstream). It is flushed by the reorder buffer on misprediction.

---
 rtl/load_buffer_if.sv | 27 ++
 rtl/load_buffer.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/load_buffer_if.sv
// Memory-controller side of the load buffer: one outstanding read request
// held until the controller pulses done with right-aligned data.
interface load_buffer_if #(
    parameter int ADDR_WIDTH = 32
);
    logic                  lbuffer_mem_req_out;
    logic [ADDR_WIDTH-1:0] lbuffer_mem_addr_out;
    logic [2:0]            lbuffer_mem_size_out;
    logic                  mem_lbuffer_done_in;
    logic [ADDR_WIDTH-1:0] mem_lbuffer_data_in;

    modport master (
        output lbuffer_mem_req_out,
        output lbuffer_mem_addr_out,
        output lbuffer_mem_size_out,
        input  mem_lbuffer_done_in,
        input  mem_lbuffer_data_in
    );

    modport slave (
        input  lbuffer_mem_req_out,
        input  lbuffer_mem_addr_out,
        input  lbuffer_mem_size_out,
        output mem_lbuffer_done_in,
        output mem_lbuffer_data_in
    );
endinterface

// File: rtl/load_buffer.sv
// In-order load queue: issues the oldest load to memory, extends the returned
// data by opcode and broadcasts it with its ROB tag on the CDB.
module load_buffer #(
    parameter int DEPTH_LOG2 = 3,
    parameter int ADDR_WIDTH = 32,
    parameter int ROB_WIDTH  = 4,
    parameter int OP_WIDTH   = 6,
    parameter logic [OP_WIDTH-1:0] OP_LB  = OP_WIDTH'(10),
    parameter logic [OP_WIDTH-1:0] OP_LH  = OP_WIDTH'(11),
    parameter logic [OP_WIDTH-1:0] OP_LW  = OP_WIDTH'(12),
    parameter logic [OP_WIDTH-1:0] OP_LBU = OP_WIDTH'(13),
    parameter logic [OP_WIDTH-1:0] OP_LHU = OP_WIDTH'(14)
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  rdy_in,
    input  logic                  addrunit_lbuffer_en_in,
    input  logic [ADDR_WIDTH-1:0] addrunit_lbuffer_a_in,
    input  logic [ROB_WIDTH-1:0]  addrunit_lbuffer_dest_in,
    input  logic [OP_WIDTH-1:0]   addrunit_lbuffer_opcode_in,
    output logic                  lbuffer_rs_full_out,
    load_buffer_if.master         mem_if,
    output logic                  lbuffer_cdb_en_out,
    output logic [ROB_WIDTH-1:0]  lbuffer_cdb_dest_out,
    output logic [ADDR_WIDTH-1:0] lbuffer_cdb_value_out,
    input  logic                  rob_lbuffer_rst_in
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE   = DEPTH_LOG2'(1);
    localparam logic [DEPTH_LOG2:0]   CNT_ONE   = (DEPTH_LOG2+1)'(1);
    localparam logic [DEPTH_LOG2:0]   CNT_FULL  = (DEPTH_LOG2+1)'(DEPTH);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_WAIT = 1'b1;

    logic [ADDR_WIDTH-1:0] addr_mem_q [DEPTH];
    logic [ROB_WIDTH-1:0]  dest_mem_q [DEPTH];
    logic [OP_WIDTH-1:0]   op_mem_q   [DEPTH];

    logic [0:0]            state_q, state_d;
    logic [DEPTH_LOG2-1:0] head_q, head_d, tail_q, tail_d;
    logic [DEPTH_LOG2:0]   count_q, count_d;
    logic                  req_q, req_d;
    logic [ADDR_WIDTH-1:0] maddr_q, maddr_d;
    logic [2:0]            msize_q, msize_d;
    logic                  cdb_en_q, cdb_en_d;
    logic [ROB_WIDTH-1:0]  cdb_dest_q, cdb_dest_d;
    logic [ADDR_WIDTH-1:0] cdb_value_q, cdb_value_d;

    logic                  full;
    logic                  enq;
    logic                  deq;
    logic [OP_WIDTH-1:0]   head_op;
    logic [ADDR_WIDTH-1:0] raw;
    logic [ADDR_WIDTH-1:0] ext;
    logic [2:0]            head_size;

    assign full    = (count_q == CNT_FULL);
    assign enq     = addrunit_lbuffer_en_in && !full && !rob_lbuffer_rst_in;
    assign head_op = op_mem_q[head_q];
    assign raw     = mem_if.mem_lbuffer_data_in;

    always_comb begin
        ext       = raw;
        head_size = 3'd4;
        if (head_op == OP_LB) begin
            ext       = {{(ADDR_WIDTH-8){raw[7]}}, raw[7:0]};
            head_size = 3'd1;
        end else if (head_op == OP_LBU) begin
            ext       = {{(ADDR_WIDTH-8){1'b0}}, raw[7:0]};
            head_size = 3'd1;
        end else if (head_op == OP_LH) begin
            ext       = {{(ADDR_WIDTH-16){raw[15]}}, raw[15:0]};
            head_size = 3'd2;
        end else if (head_op == OP_LHU) begin
            ext       = {{(ADDR_WIDTH-16){1'b0}}, raw[15:0]};
            head_size = 3'd2;
        end
    end

    always_comb begin
        state_d     = state_q;
        head_d      = head_q;
        tail_d      = tail_q;
        count_d     = count_q;
        req_d       = req_q;
        maddr_d     = maddr_q;
        msize_d     = msize_q;
        cdb_en_d    = 1'b0;
        cdb_dest_d  = cdb_dest_q;
        cdb_value_d = cdb_value_q;
        deq         = 1'b0;
        if (rob_lbuffer_rst_in) begin
            state_d = S_IDLE;
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
            req_d   = 1'b0;
        end else begin
            if (enq) tail_d = tail_q + PTR_ONE;
            case (state_q)
                S_IDLE: begin
                    if (count_q != '0) begin
                        req_d   = 1'b1;
                        maddr_d = addr_mem_q[head_q];
                        msize_d = head_size;
                        state_d = S_WAIT;
                    end
                end
                default: begin
                    if (mem_if.mem_lbuffer_done_in) begin
                        req_d       = 1'b0;
                        cdb_en_d    = 1'b1;
                        cdb_dest_d  = dest_mem_q[head_q];
                        cdb_value_d = ext;
                        head_d      = head_q + PTR_ONE;
                        deq         = 1'b1;
                        state_d     = S_IDLE;
                    end
                end
            endcase
            // Simultaneous enqueue and dequeue leave the count unchanged.
            if (enq && !deq)      count_d = count_q + CNT_ONE;
            else if (!enq && deq) count_d = count_q - CNT_ONE;
        end
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in && rdy_in && enq) begin
            addr_mem_q[tail_q] <= addrunit_lbuffer_a_in;
            dest_mem_q[tail_q] <= addrunit_lbuffer_dest_in;
            op_mem_q[tail_q]   <= addrunit_lbuffer_opcode_in;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q     <= S_IDLE;
            head_q      <= '0;
            tail_q      <= '0;
            count_q     <= '0;
            req_q       <= 1'b0;
            maddr_q     <= '0;
            msize_q     <= '0;
            cdb_en_q    <= 1'b0;
            cdb_dest_q  <= '0;
            cdb_value_q <= '0;
        end else if (rdy_in) begin
            state_q     <= state_d;
            head_q      <= head_d;
            tail_q      <= tail_d;
            count_q     <= count_d;
            req_q       <= req_d;
            maddr_q     <= maddr_d;
            msize_q     <= msize_d;
            cdb_en_q    <= cdb_en_d;
            cdb_dest_q  <= cdb_dest_d;
            cdb_value_q <= cdb_value_d;
        end
    end

    assign lbuffer_rs_full_out         = full;
    assign mem_if.lbuffer_mem_req_out  = req_q;
    assign mem_if.lbuffer_mem_addr_out = maddr_q;
    assign mem_if.lbuffer_mem_size_out = msize_q;
    assign lbuffer_cdb_en_out          = cdb_en_q;
    assign lbuffer_cdb_dest_out        = cdb_dest_q;
    assign lbuffer_cdb_value_out       = cdb_value_q;
endmodule
